// File: rtl/cmp_sweep_pkg.sv
// Shared types and sizes for the 2-bit comparator sweep controller.
package cmp_sweep_pkg;

  localparam int unsigned NUM_VEC = 16;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned HOLD_W  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StSample,
    StFinish
  } state_e;

endpackage

// File: rtl/cmp2_ref.sv
// Golden 2-bit magnitude compare: operand A is idx[3:2], operand B is idx[1:0].
module cmp2_ref
  import cmp_sweep_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  output logic [2:0]       exp_o
);

  logic [1:0] op_a;
  logic [1:0] op_b;

  assign op_a  = idx_i[3:2];
  assign op_b  = idx_i[1:0];
  // {gt, eq, lt}
  assign exp_o = {op_a > op_b, op_a == op_b, op_a < op_b};

endmodule

// File: rtl/cmp_sweep_ctrl.sv
// Sweeps all 16 operand pairs through an external 2-bit comparator and tallies its results.
// Define CMP_SWEEP_STOP_ON_ERR_EN to end the sweep at the first mismatching vector.
module cmp_sweep_ctrl
  import cmp_sweep_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  input  logic       f1,
  input  logic       f2,
  input  logic       f3,
  output logic       busy,
  output logic       done,
  output logic [4:0] gt_cnt,
  output logic [4:0] eq_cnt,
  output logic [4:0] lt_cnt,
  output logic [4:0] err_cnt,
  output logic       err,
  output logic [3:0] fail_idx
);

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    vec_q;
  logic [HOLD_W-1:0]   hold_q;
  logic                busy_q;
  logic                done_q;
  logic [CNT_W-1:0]    gt_cnt_q;
  logic [CNT_W-1:0]    eq_cnt_q;
  logic [CNT_W-1:0]    lt_cnt_q;
  logic [CNT_W-1:0]    err_cnt_q;
  logic                err_q;
  logic [IDX_W-1:0]    fail_idx_q;

  logic [2:0] exp_res;
  logic       mismatch;
  logic       stop_on_err;
  logic       last_vec;

  cmp2_ref u_cmp2_ref (
    .idx_i (idx_q),
    .exp_o (exp_res)
  );

  assign mismatch = ({f1, f2, f3} != exp_res);
  assign last_vec = (idx_q == IDX_W'(NUM_VEC - 1));

`ifdef CMP_SWEEP_STOP_ON_ERR_EN
  assign stop_on_err = mismatch;
`else
  assign stop_on_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      vec_q      <= '0;
      hold_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      gt_cnt_q   <= '0;
      eq_cnt_q   <= '0;
      lt_cnt_q   <= '0;
      err_cnt_q  <= '0;
      err_q      <= 1'b0;
      fail_idx_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StHold;
            idx_q      <= '0;
            vec_q      <= '0;
            hold_q     <= HOLD_W'(SETTLE);
            busy_q     <= 1'b1;
            gt_cnt_q   <= '0;
            eq_cnt_q   <= '0;
            lt_cnt_q   <= '0;
            err_cnt_q  <= '0;
            err_q      <= 1'b0;
            fail_idx_q <= '0;
          end
        end
        StHold: begin
          if (hold_q == HOLD_W'(1)) begin
            state_q <= StSample;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        StSample: begin
          gt_cnt_q <= gt_cnt_q + CNT_W'(f1);
          eq_cnt_q <= eq_cnt_q + CNT_W'(f2);
          lt_cnt_q <= lt_cnt_q + CNT_W'(f3);
          if (mismatch) begin
            err_cnt_q <= err_cnt_q + 1'b1;
            err_q     <= 1'b1;
            // err_q is still low only for the first mismatch of this sweep
            if (!err_q) begin
              fail_idx_q <= idx_q;
            end
          end
          if (last_vec || stop_on_err) begin
            state_q <= StFinish;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            vec_q   <= '0;
          end else begin
            state_q <= StHold;
            idx_q   <= idx_q + 1'b1;
            vec_q   <= idx_q + 1'b1;
            hold_q  <= HOLD_W'(SETTLE);
          end
        end
        StFinish: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign {a, b, c, d} = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign gt_cnt       = gt_cnt_q;
  assign eq_cnt       = eq_cnt_q;
  assign lt_cnt       = lt_cnt_q;
  assign err_cnt      = err_cnt_q;
  assign err          = err_q;
  assign fail_idx     = fail_idx_q;

endmodule

// File: tb/tb_cmp_sweep_ctrl.sv
// Bench for cmp_sweep_ctrl: SETTLE=1 and SETTLE=3 instances driven by a faultable comparator,
// checked every cycle against a cycle-count model of the sweep.
module tb_cmp_sweep_ctrl;

`ifdef CMP_SWEEP_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [3:0] vec;
    logic [4:0] gt;
    logic [4:0] eq;
    logic [4:0] lt;
    logic [4:0] ec;
    logic       err;
    logic [3:0] fi;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  int   fault_mode = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic a_s1, b_s1, c_s1, d_s1, f1_s1, f2_s1, f3_s1, busy_s1, done_s1, err_s1;
  logic [4:0] gt_s1, eq_s1, lt_s1, ec_s1;
  logic [3:0] fi_s1;
  logic a_s3, b_s3, c_s3, d_s3, f1_s3, f2_s3, f3_s3, busy_s3, done_s3, err_s3;
  logic [4:0] gt_s3, eq_s3, lt_s3, ec_s3;
  logic [3:0] fi_s3;

  // Spec rule: A = v[3:2], B = v[1:0], result {A>B, A==B, A<B}
  function automatic logic [2:0] true_cmp(input int v);
    int x;
    int y;
    x = v / 4;
    y = v % 4;
    return {x > y, x == y, x < y};
  endfunction

  // Comparator under test: 0 correct, 1 f2 stuck at 0, 2 f1 inverted
  function automatic logic [2:0] env_cmp(input int v, input int flt);
    logic [2:0] r;
    r = true_cmp(v);
    if (flt == 1) r[1] = 1'b0;
    else if (flt == 2) r[2] = ~r[2];
    return r;
  endfunction

  assign {f1_s1, f2_s1, f3_s1} = env_cmp(int'({a_s1, b_s1, c_s1, d_s1}), fault_mode);
  assign {f1_s3, f2_s3, f3_s3} = env_cmp(int'({a_s3, b_s3, c_s3, d_s3}), fault_mode);

  cmp_sweep_ctrl #(.SETTLE(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a_s1), .b(b_s1), .c(c_s1), .d(d_s1),
    .f1(f1_s1), .f2(f2_s1), .f3(f3_s1),
    .busy(busy_s1), .done(done_s1),
    .gt_cnt(gt_s1), .eq_cnt(eq_s1), .lt_cnt(lt_s1), .err_cnt(ec_s1),
    .err(err_s1), .fail_idx(fi_s1)
  );

  cmp_sweep_ctrl #(.SETTLE(3)) dut_s3 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a_s3), .b(b_s3), .c(c_s3), .d(d_s3),
    .f1(f1_s3), .f2(f2_s3), .f3(f3_s3),
    .busy(busy_s3), .done(done_s3),
    .gt_cnt(gt_s3), .eq_cnt(eq_s3), .lt_cnt(lt_s3), .err_cnt(ec_s3),
    .err(err_s3), .fail_idx(fi_s3)
  );

  // ---------------- model ----------------
  localparam int PER [2] = '{2, 4};  // SETTLE + 1 per instance
  int mk   [2] = '{0, 0};            // cycle number since accepted start (1 = first busy cycle)
  bit mrun [2] = '{0, 0};
  int mflt [2] = '{0, 0};

  function automatic int first_bad(input int flt);
    for (int v = 0; v < 16; v++) begin
      if (env_cmp(v, flt) != true_cmp(v)) return v;
    end
    return 16;
  endfunction

  function automatic int end_k(input int p, input int flt);
    int m;
    int last;
    m = first_bad(flt);
    last = (STOP && m < 16) ? m : 15;
    return (last + 1) * p;
  endfunction

  function automatic obs_t model(input int p, input int flt, input int k, input bit run);
    obs_t e;
    int endk;
    int n;
    logic [2:0] f;
    e = '0;
    if (!run) return e;
    endk = end_k(p, flt);
    if (k <= endk) begin
      e.busy = 1'b1;
      e.vec  = 4'((k - 1) / p);
      n      = (k - 1) / p;
    end else begin
      e.done = (k == endk + 1);
      n      = endk / p;
    end
    for (int v = 0; v < n; v++) begin
      f    = env_cmp(v, flt);
      e.gt = e.gt + 5'(f[2]);
      e.eq = e.eq + 5'(f[1]);
      e.lt = e.lt + 5'(f[0]);
      if (f != true_cmp(v)) begin
        if (e.ec == 0) e.fi = 4'(v);
        e.ec = e.ec + 5'd1;
      end
    end
    e.err = (e.ec != 0);
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mrun[i] <= 1'b0;
        mk[i]   <= 0;
      end else if (start && (!mrun[i] || mk[i] >= end_k(PER[i], mflt[i]) + 2)) begin
        mrun[i] <= 1'b1;
        mk[i]   <= 1;
        mflt[i] <= fault_mode;
      end else if (mrun[i]) begin
        mk[i] <= mk[i] + 1;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      if (errors <= 40) $display("FAIL %s act=%0d req=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic cmp_obs(input string tag, input obs_t got, input obs_t e);
    chk({tag, "_busy"}, int'(got.busy), int'(e.busy));
    chk({tag, "_done"}, int'(got.done), int'(e.done));
    chk({tag, "_abcd"}, int'(got.vec), int'(e.vec));
    chk({tag, "_gt_cnt"}, int'(got.gt), int'(e.gt));
    chk({tag, "_eq_cnt"}, int'(got.eq), int'(e.eq));
    chk({tag, "_lt_cnt"}, int'(got.lt), int'(e.lt));
    chk({tag, "_err_cnt"}, int'(got.ec), int'(e.ec));
    chk({tag, "_err"}, int'(got.err), int'(e.err));
    chk({tag, "_fail_idx"}, int'(got.fi), int'(e.fi));
  endtask

  obs_t got_s1, got_s3;
  assign got_s1 = {busy_s1, done_s1, a_s1, b_s1, c_s1, d_s1,
                   gt_s1, eq_s1, lt_s1, ec_s1, err_s1, fi_s1};
  assign got_s3 = {busy_s3, done_s3, a_s3, b_s3, c_s3, d_s3,
                   gt_s3, eq_s3, lt_s3, ec_s3, err_s3, fi_s3};

  always @(negedge clk) begin
    cmp_obs("s1", got_s1, model(PER[0], mflt[0], mk[0], mrun[0]));
    cmp_obs("s3", got_s3, model(PER[1], mflt[1], mk[1], mrun[1]));
  end

  // ---------------- stimulus ----------------
  int busy_n1, busy_n3, done_n1, done_n3, done_at1;

  task automatic sweep(input int flt, input int restart_at);
    busy_n1 = 0; busy_n3 = 0; done_n1 = 0; done_n3 = 0; done_at1 = 0;
    @(negedge clk);
    fault_mode = flt;
    start = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      start = (c == restart_at);
      if (busy_s1) busy_n1++;
      if (busy_s3) busy_n3++;
      if (done_s3) done_n3++;
      if (done_s1) begin
        done_n1++;
        if (done_at1 == 0) done_at1 = c;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs_s1", int'(got_s1), 0);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_autostart", int'(busy_s1), 0);

    // correct comparator: 6 gt, 4 eq, 6 lt
    sweep(0, 0);
    chk("ok_busy_cycles_s1", busy_n1, 32);
    chk("ok_busy_cycles_s3", busy_n3, 64);
    chk("ok_done_pulses_s1", done_n1, 1);
    chk("ok_done_pulses_s3", done_n3, 1);
    chk("ok_gt_s1", int'(gt_s1), 6);
    chk("ok_eq_s1", int'(eq_s1), 4);
    chk("ok_lt_s1", int'(lt_s1), 6);
    chk("ok_err_cnt_s1", int'(ec_s1), 0);
    chk("ok_err_s1", int'(err_s1), 0);
    chk("ok_fail_idx_s1", int'(fi_s1), 0);
    chk("ok_eq_s3", int'(eq_s3), 4);

    // f2 stuck at 0: the 4 equal vectors mismatch, first is 0000
    sweep(1, 0);
    chk("f2s0_eq_s1", int'(eq_s1), 0);
    chk("f2s0_err_cnt_s1", int'(ec_s1), STOP ? 1 : 4);
    chk("f2s0_fail_idx_s1", int'(fi_s1), 0);
    chk("f2s0_err_s1", int'(err_s1), 1);

    // start re-asserted at busy cycle 5 is ignored
    sweep(0, 5);
    chk("restart_busy_s1", busy_n1, 32);
    chk("restart_busy_s3", busy_n3, 64);
    chk("restart_done_s1", done_n1, 1);

    // reset at busy cycle 10, then a clean rerun
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_outputs_s1", int'(got_s1), 0);
    chk("midrst_outputs_s3", int'(got_s3), 0);
    #2 rst_n = 1'b1;
    sweep(0, 0);
    chk("rerun_busy_s1", busy_n1, 32);
    chk("rerun_gt_s1", int'(gt_s1), 6);
    chk("rerun_eq_s1", int'(eq_s1), 4);
    chk("rerun_lt_s1", int'(lt_s1), 6);
    chk("rerun_err_cnt_s1", int'(ec_s1), 0);

    // f1 inverted: every vector mismatches
    sweep(2, 0);
    chk("f1inv_fail_idx_s1", int'(fi_s1), 0);
    chk("f1inv_err_s1", int'(err_s1), 1);
    if (STOP) begin
      // done rises on the second edge after the accepting edge
      chk("stop_done_latency_s1", done_at1 - 1, 2);
      chk("stop_err_cnt_s1", int'(ec_s1), 1);
      chk("stop_busy_s1", busy_n1, 2);
    end else begin
      chk("f1inv_err_cnt_s1", int'(ec_s1), 16);
      chk("f1inv_gt_s1", int'(gt_s1), 10);
      chk("f1inv_busy_s1", busy_n1, 32);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
